// File: rtl/psx_irq_ctrl.sv
// PSX interrupt controller: up to 32 latched sources with per-channel edge/level mode and polarity.
// Optional macro PSX_IRQ_SYNC_EN adds a two-flop synchronizer on every irq_i bit.
module psx_irq_ctrl #(
    parameter int          NUM_IRQ  = 11,
    parameter logic [31:0] IRQ_POL  = 32'h0,
    parameter logic [31:0] MODE_RST = 32'h0
) (
    input  logic               sys_clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               wen,
    input  logic               ren,
    input  logic [1:0]         addr,
    input  logic [3:0]         ben,
    input  logic [31:0]        data_i,
    output logic [31:0]        rdata_o,
    output logic [31:0]        stat_o,
    output logic [31:0]        mask_o,
    output logic               irq_o,
    output logic [4:0]         irq_id_o
);

    localparam logic [31:0] VALID = (NUM_IRQ >= 32) ? 32'hFFFF_FFFF
                                                    : ((32'h1 << NUM_IRQ) - 32'h1);

    logic [31:0] src;
    logic [31:0] s, set, lm;
    logic [31:0] stat_q, stat_d, mask_q, mask_d, mode_q, mode_d, prev_q;
    logic [31:0] rdata_q, rdata_d, pend;
    logic        irq_q;
    logic [4:0]  id_q, id_d;
    logic        wr_stat, wr_mask, wr_mode, wr_force;

`ifdef PSX_IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] sync1_q, sync2_q;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_i;
            sync2_q <= sync1_q;
        end
    end

    assign src = 32'(sync2_q);
`else
    assign src = 32'(irq_i);
`endif

    assign s   = (src ^ IRQ_POL) & VALID;
    // Level channels set every cycle; edge channels only on a 0->1 of the conditioned input.
    assign set = s & (mode_q | ~prev_q);
    assign lm  = {{8{ben[3]}}, {8{ben[2]}}, {8{ben[1]}}, {8{ben[0]}}};

    assign wr_stat  = wen && (addr == 2'd0);
    assign wr_mask  = wen && (addr == 2'd1);
    assign wr_mode  = wen && (addr == 2'd2);
    assign wr_force = wen && (addr == 2'd3);

    always_comb begin
        stat_d = stat_q;
        if (wr_stat)  stat_d = stat_q & (data_i | ~lm);
        if (wr_force) stat_d = stat_q | (data_i & lm);
        stat_d = (stat_d | set) & VALID;

        mask_d = mask_q;
        if (wr_mask) mask_d = ((mask_q & ~lm) | (data_i & lm)) & VALID;

        mode_d = mode_q;
        if (wr_mode) mode_d = ((mode_q & ~lm) | (data_i & lm)) & VALID;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (ren) begin
            case (addr)
                2'd0:    rdata_d = stat_q;
                2'd1:    rdata_d = mask_q;
                2'd2:    rdata_d = mode_q;
                default: rdata_d = 32'h0;
            endcase
        end
    end

    assign pend = stat_q & mask_q;

    // Scan downward so the lowest pending index wins.
    always_comb begin
        id_d = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (pend[i]) id_d = 5'(i);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            stat_q  <= '0;
            mask_q  <= '0;
            mode_q  <= MODE_RST & VALID;
            prev_q  <= '0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
            id_q    <= '0;
        end else begin
            stat_q  <= stat_d;
            mask_q  <= mask_d;
            mode_q  <= mode_d;
            prev_q  <= s;
            rdata_q <= rdata_d;
            irq_q   <= |pend;
            id_q    <= id_d;
        end
    end

    assign rdata_o  = rdata_q;
    assign stat_o   = stat_q;
    assign mask_o   = mask_q;
    assign irq_o    = irq_q;
    assign irq_id_o = id_q;

endmodule

// File: tb/tb_psx_irq_ctrl.sv
module tb_psx_irq_ctrl;

    localparam int F_STAT = 0, F_MASK = 1, F_IRQ = 2, F_ID = 3, F_RD = 4;

    typedef struct {
        int          cyc;
        int          d;
        int          f;
        logic [31:0] v;
        string       nm;
    } exp_t;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] irq0 = '0;
    logic [3:0]  irq1 = 4'b0001;
    logic        wen_s [2];
    logic        ren_s [2];
    logic [1:0]  addr_s [2];
    logic [3:0]  ben_s [2];
    logic [31:0] dat_s [2];
    logic [31:0] rd_o [2], stat_o [2], mask_o [2];
    logic        irq_o [2];
    logic [4:0]  id_o [2];

    int   cyc = 0;
    int   ntests = 0;
    int   nfail = 0;
    exp_t q[$];

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    psx_irq_ctrl u0 (
        .sys_clk(sys_clk), .rst(rst), .irq_i(irq0),
        .wen(wen_s[0]), .ren(ren_s[0]), .addr(addr_s[0]), .ben(ben_s[0]), .data_i(dat_s[0]),
        .rdata_o(rd_o[0]), .stat_o(stat_o[0]), .mask_o(mask_o[0]),
        .irq_o(irq_o[0]), .irq_id_o(id_o[0])
    );

    psx_irq_ctrl #(.NUM_IRQ(4), .IRQ_POL(32'h1), .MODE_RST(32'h0)) u1 (
        .sys_clk(sys_clk), .rst(rst), .irq_i(irq1),
        .wen(wen_s[1]), .ren(ren_s[1]), .addr(addr_s[1]), .ben(ben_s[1]), .data_i(dat_s[1]),
        .rdata_o(rd_o[1]), .stat_o(stat_o[1]), .mask_o(mask_o[1]),
        .irq_o(irq_o[1]), .irq_id_o(id_o[1])
    );

    function automatic logic [31:0] got(int d, int f);
        case (f)
            F_STAT:  return stat_o[d];
            F_MASK:  return mask_o[d];
            F_IRQ:   return {31'h0, irq_o[d]};
            F_ID:    return {27'h0, id_o[d]};
            default: return rd_o[d];
        endcase
    endfunction

    always @(negedge sys_clk) begin
        for (int i = 0; i < q.size();) begin
            if (q[i].cyc == cyc) begin
                ntests++;
                if (got(q[i].d, q[i].f) !== q[i].v) begin
                    nfail++;
                    $display("FAIL %s (dut%0d): got 0x%08h expected 0x%08h",
                             q[i].nm, q[i].d, got(q[i].d, q[i].f), q[i].v);
                end
                q.delete(i);
            end else begin
                i++;
            end
        end
    end

    function automatic void ex(int d, int f, logic [31:0] v, int dl, string nm);
        exp_t e;
        e.cyc = cyc + dl; e.d = d; e.f = f; e.v = v; e.nm = nm;
        q.push_back(e);
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic acc(int d, bit we, bit re, logic [1:0] ad, logic [31:0] v, logic [3:0] be);
        wen_s[d] = we; ren_s[d] = re; addr_s[d] = ad; dat_s[d] = v; ben_s[d] = be;
        tick();
        wen_s[d] = 1'b0; ren_s[d] = 1'b0; addr_s[d] = 2'd0; dat_s[d] = '0; ben_s[d] = 4'h0;
    endtask

    task automatic wr(int d, logic [1:0] ad, logic [31:0] v);
        acc(d, 1'b1, 1'b0, ad, v, 4'hF);
    endtask

    task automatic rd(int d, logic [1:0] ad);
        acc(d, 1'b0, 1'b1, ad, 32'h0, 4'h0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            wen_s[d] = 1'b0; ren_s[d] = 1'b0; addr_s[d] = 2'd0; ben_s[d] = 4'h0; dat_s[d] = '0;
        end
        tick(); tick();
        for (int d = 0; d < 2; d++) begin
            ex(d, F_STAT, 0, 0, "rst_stat"); ex(d, F_MASK, 0, 0, "rst_mask");
            ex(d, F_IRQ, 0, 0, "rst_irq");   ex(d, F_ID, 0, 0, "rst_id");
            ex(d, F_RD, 0, 0, "rst_rd");
        end
        rst = 1'b0;
        tick();

        irq0[0] = 1'b1; tick(); irq0[0] = 1'b0;
        ex(0, F_STAT, 32'h1, 0, "pulse_stat"); ex(0, F_IRQ, 0, 0, "pulse_irq_masked");
        wr(0, 2'd1, 32'h1);
        ex(0, F_IRQ, 0, 0, "mask_irq_same_edge");
        ex(0, F_IRQ, 1, 1, "mask_irq"); ex(0, F_ID, 0, 1, "mask_id0");
        wr(0, 2'd0, 32'h0);
        ex(0, F_STAT, 0, 0, "ack_stat"); ex(0, F_IRQ, 0, 1, "ack_irq");
        tick();

        wr(0, 2'd1, 32'h7FF);
        irq0[3] = 1'b1; irq0[7] = 1'b1; tick(); irq0 = '0;
        ex(0, F_STAT, 32'h88, 0, "src37_stat");
        ex(0, F_ID, 3, 1, "id3"); ex(0, F_IRQ, 1, 1, "irq37");
        wr(0, 2'd0, ~32'h8);
        ex(0, F_STAT, 32'h80, 0, "ack3_stat"); ex(0, F_ID, 7, 1, "id7");
        wr(0, 2'd0, ~32'h80);
        ex(0, F_STAT, 0, 0, "ack7_stat"); ex(0, F_IRQ, 0, 1, "irq_off"); ex(0, F_ID, 0, 1, "id_none");
        tick();

        irq0[5] = 1'b1;
        acc(0, 1'b1, 1'b0, 2'd0, 32'h0, 4'hF);
        irq0[5] = 1'b0;
        ex(0, F_STAT, 32'h20, 0, "set_beats_ack");
        wr(0, 2'd0, 32'h0);
        ex(0, F_STAT, 0, 0, "clear5"); ex(0, F_ID, 5, 0, "id5");

        wr(0, 2'd2, 32'h4);
        irq0[2] = 1'b1; tick();
        ex(0, F_STAT, 32'h4, 0, "level_set");
        wr(0, 2'd0, 32'h0);
        ex(0, F_STAT, 32'h4, 0, "level_ack_held");
        irq0[2] = 1'b0;
        wr(0, 2'd0, 32'h0);
        ex(0, F_STAT, 0, 0, "level_ack_released");
        rd(0, 2'd2);
        ex(0, F_RD, 32'h4, 0, "rd_mode");

        wr(0, 2'd3, 32'h101);
        ex(0, F_STAT, 32'h101, 0, "force_101");
        acc(0, 1'b1, 1'b0, 2'd0, 32'h0, 4'b0001);
        ex(0, F_STAT, 32'h100, 0, "lane_ack");
        wr(0, 2'd0, 32'h0);
        acc(0, 1'b1, 1'b0, 2'd1, 32'h0, 4'b0010);
        ex(0, F_MASK, 32'hFF, 0, "lane_mask");
        acc(0, 1'b1, 1'b1, 2'd1, 32'h3, 4'hF);
        ex(0, F_RD, 32'hFF, 0, "rd_old_on_write"); ex(0, F_MASK, 32'h3, 0, "mask3");
        rd(0, 2'd3);
        ex(0, F_RD, 0, 0, "rd_force_zero");

        irq1[0] = 1'b0; tick();
        ex(1, F_STAT, 32'h1, 0, "pol_edge");
        wr(1, 2'd3, 32'hF0);
        ex(1, F_STAT, 32'h1, 0, "force_hi_ignored");
        wr(1, 2'd3, 32'h2);
        ex(1, F_STAT, 32'h3, 0, "force_2");
        rd(1, 2'd1);
        ex(1, F_RD, 0, 0, "rd_mask1");
        wr(1, 2'd1, 32'hFF);
        ex(1, F_MASK, 32'hF, 0, "mask_truncated");

        wr(0, 2'd3, 32'h3);
        tick();
        ex(0, F_IRQ, 1, 0, "pre_rst_irq");
        rst = 1'b1; tick();
        ex(0, F_STAT, 0, 0, "rst2_stat"); ex(0, F_MASK, 0, 0, "rst2_mask");
        ex(0, F_IRQ, 0, 0, "rst2_irq");   ex(0, F_ID, 0, 0, "rst2_id");
        ex(0, F_RD, 0, 0, "rst2_rd");
        rst = 1'b0;
        rd(0, 2'd2);
        ex(0, F_RD, 0, 0, "rst2_mode");
        tick(); tick();

        ntests++;
        if (stat_o[0] !== 32'h0) begin
            nfail++; $display("FAIL end_stat: got 0x%08h", stat_o[0]);
        end
        ntests++;
        if (mask_o[0] !== 32'h0) begin
            nfail++; $display("FAIL end_mask: got 0x%08h", mask_o[0]);
        end
        ntests++;
        if (irq_o[0] !== 1'b0) begin
            nfail++; $display("FAIL end_irq: got %0b", irq_o[0]);
        end
        ntests++;
        if (id_o[0] !== 5'd0) begin
            nfail++; $display("FAIL end_id: got %0d", id_o[0]);
        end
        ntests++;
        if (rd_o[0] !== 32'h0) begin
            nfail++; $display("FAIL end_rd_mode: got 0x%08h", rd_o[0]);
        end

        foreach (q[i]) begin
            ntests++; nfail++;
            $display("FAIL %s (dut%0d): never checked, expected 0x%08h", q[i].nm, q[i].d, q[i].v);
        end
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
